// File: rtl/wb_rf_hilo_pkg.sv
// WB-to-RF bus layout shared by the register file and its users.
// Field widths and the packed bus struct; no ports.
package wb_rf_hilo_pkg;

  localparam int WB_TO_RF_WD = 104;
  localparam int XLEN        = 32;
  localparam int RA_W        = 5;

  typedef struct packed {
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] hi_wdata;
    logic [XLEN-1:0] lo_wdata;
    logic            rf_we;
    logic [RA_W-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;
  } wb_rf_t;

  function automatic logic gpr_wr(
    input wb_rf_t b
  );
    return b.rf_we && (b.rf_waddr != '0);
  endfunction

endpackage

// File: rtl/wb_rf_hilo_if.sv
// WB/ID side bundle of the register file: write bus, read addrs/data.
// master = WB+ID driver side, slave = register file.
interface wb_rf_hilo_if;
  import wb_rf_hilo_pkg::*;

  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus;
  logic [RA_W-1:0]        raddr1;
  logic [RA_W-1:0]        raddr2;
  logic [XLEN-1:0]        rdata1;
  logic [XLEN-1:0]        rdata2;
  logic [XLEN-1:0]        hi_rdata;
  logic [XLEN-1:0]        lo_rdata;

  modport master (
    output wb_to_rf_bus, raddr1, raddr2,
    input  rdata1, rdata2, hi_rdata, lo_rdata
  );

  modport slave (
    input  wb_to_rf_bus, raddr1, raddr2,
    output rdata1, rdata2, hi_rdata, lo_rdata
  );

endinterface

// File: rtl/wb_rf_hilo_hilo_reg.sv
// HI/LO pair with independent write enables and optional bypass.
// Ports: clk, rst, i_hi_we/i_lo_we, i_*_wdata in, o_*_rdata out.
module hilo_reg
  import wb_rf_hilo_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_hi_we,
  input  logic            i_lo_we,
  input  logic [XLEN-1:0] i_hi_wdata,
  input  logic [XLEN-1:0] i_lo_wdata,
  output logic [XLEN-1:0] o_hi_rdata,
  output logic [XLEN-1:0] o_lo_rdata
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_wdata;
      if (i_lo_we) r_lo <= i_lo_wdata;
    end
  end

  // Outputs forced to 0 while in reset, bypass included.
  always_comb begin
    o_hi_rdata = r_hi;
    o_lo_rdata = r_lo;
    if (BYPASS && i_hi_we) o_hi_rdata = i_hi_wdata;
    if (BYPASS && i_lo_we) o_lo_rdata = i_lo_wdata;
    if (rst) begin
      o_hi_rdata = '0;
      o_lo_rdata = '0;
    end
  end

endmodule

// File: rtl/wb_rf_hilo.sv
// 32x32 GPR file plus HI/LO, written from the WB-to-RF bus.
// Ports: clk, rst, bus (slave: write bus, 2 GPR reads, HI/LO reads).
module wb_rf_hilo
  import wb_rf_hilo_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int RF_WD  = WB_TO_RF_WD
) (
  input  logic         clk,
  input  logic         rst,
  wb_rf_hilo_if.slave  bus
);

  logic [RF_WD-1:0] w_raw;
  wb_rf_t           w_bus;
  logic             w_wr;
  logic [XLEN-1:0]  r_regs [32];

  assign w_raw = bus.wb_to_rf_bus;
  assign w_bus = wb_rf_t'(w_raw);
  assign w_wr  = gpr_wr(w_bus);

  // Entry 0 is never written, so $0 stays 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[w_bus.rf_waddr] <= w_bus.rf_wdata;
    end
  end

  always_comb begin
    bus.rdata1 = '0;
    if (bus.raddr1 != '0) begin
      bus.rdata1 = r_regs[bus.raddr1];
      if (BYPASS && w_wr && bus.raddr1 == w_bus.rf_waddr)
        bus.rdata1 = w_bus.rf_wdata;
    end
    if (rst) bus.rdata1 = '0;
  end

  always_comb begin
    bus.rdata2 = '0;
    if (bus.raddr2 != '0) begin
      bus.rdata2 = r_regs[bus.raddr2];
      if (BYPASS && w_wr && bus.raddr2 == w_bus.rf_waddr)
        bus.rdata2 = w_bus.rf_wdata;
    end
    if (rst) bus.rdata2 = '0;
  end

  hilo_reg #(
    .BYPASS (BYPASS)
  ) u_hilo (
    .clk        (clk),
    .rst        (rst),
    .i_hi_we    (w_bus.hi_we),
    .i_lo_we    (w_bus.lo_we),
    .i_hi_wdata (w_bus.hi_wdata),
    .i_lo_wdata (w_bus.lo_wdata),
    .o_hi_rdata (bus.hi_rdata),
    .o_lo_rdata (bus.lo_rdata)
  );

endmodule

// File: tb/tb_wb_rf_hilo.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances, same stimulus.
// Expected values queued at drive time, popped at sample time.
module tb_wb_rf_hilo;
  import wb_rf_hilo_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_q[$];

  wb_rf_hilo_if if0 ();
  wb_rf_hilo_if if1 ();

  wb_rf_hilo #(.BYPASS(1'b1), .RF_WD(WB_TO_RF_WD)) u_byp (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  wb_rf_hilo #(.BYPASS(1'b0), .RF_WD(WB_TO_RF_WD)) u_nob (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(
    input logic        hwe, lwe,
    input logic [31:0] hd, ld,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    wb_rf_t b;
    b = {hwe, lwe, hd, ld, we, wa, wd};
    if0.wb_to_rf_bus = b;
    if1.wb_to_rf_bus = b;
  endtask

  task automatic raddr(input logic [4:0] a1, a2);
    if0.raddr1 = a1; if0.raddr2 = a2;
    if1.raddr1 = a1; if1.raddr2 = a2;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    logic [31:0] obs [8];
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    raddr(5'd1, 5'd31);
    #1;
    obs = '{if0.rdata1, if0.rdata2, if0.hi_rdata, if0.lo_rdata,
            if1.rdata1, if1.rdata2, if1.hi_rdata, if1.lo_rdata};
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h0);
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      if (obs[k] !== e) begin
        $display("FAIL reset_state[%0d] got=%h exp=%h", k, obs[k], e);
        n_err++;
      end
      n_cmp++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_gpr;
    logic [31:0] e;
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    raddr(5'd5, 5'd6);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front();
    if (if1.rdata1 !== e) begin
      $display("FAIL gpr_rd1 got=%h exp=%h", if1.rdata1, e);
      n_err++;
    end
    n_cmp++;
    e = exp_q.pop_front();
    if (if1.rdata2 !== e) begin
      $display("FAIL gpr_rd2 got=%h exp=%h", if1.rdata2, e);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_bypass;
    logic [31:0] e;
    logic [31:0] obs [3];
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 5'd9, 32'h12345678);
    raddr(5'd9, 5'd9);
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h0);
    #1;
    obs = '{if0.rdata1, if0.rdata2, if1.rdata1};
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      if (obs[k] !== e) begin
        $display("FAIL bypass_pre[%0d] got=%h exp=%h", k, obs[k], e);
        n_err++;
      end
      n_cmp++;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(32'h12345678);
    e = exp_q.pop_front();
    if (if1.rdata2 !== e) begin
      $display("FAIL nobypass_post got=%h exp=%h", if1.rdata2, e);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_zero;
    logic [31:0] e;
    logic [31:0] obs [4];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
      else drive(0, 0, 0, 0, 0, 0, 0);
      raddr(5'd0, 5'd0);
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
      #1;
      obs = '{if0.rdata1, if0.rdata2, if1.rdata1, if1.rdata2};
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin
          $display("FAIL zero_reg c%0d[%0d] got=%h exp=%h", c, k, obs[k], e);
          n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_hilo;
    logic [31:0] e;
    logic [31:0] obs [4];
    @(negedge clk);
    drive(1, 1, 32'h1, 32'h2, 0, 0, 0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    obs = '{if0.hi_rdata, if0.lo_rdata, if1.hi_rdata, if1.lo_rdata};
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      if (obs[k] !== e) begin
        $display("FAIL hilo_byp_A[%0d] got=%h exp=%h", k, obs[k], e);
        n_err++;
      end
      n_cmp++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        drive(0, 1, 32'hx, 32'h3, 0, 0, 0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h3);
      end
      #1;
      e = exp_q.pop_front();
      if (if1.hi_rdata !== e) begin
        $display("FAIL hilo_hi c%0d got=%h exp=%h", c, if1.hi_rdata, e);
        n_err++;
      end
      n_cmp++;
      e = exp_q.pop_front();
      if (if1.lo_rdata !== e) begin
        $display("FAIL hilo_lo c%0d got=%h exp=%h", c, if1.lo_rdata, e);
        n_err++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_combo_reset;
    logic [31:0] e;
    logic [31:0] obs [4];
    @(negedge clk);
    drive(1, 0, 32'h5A5A5A5A, 0, 1, 5'd31, 32'hA5A5A5A5);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    raddr(5'd31, 5'd31);
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(32'h5A5A5A5A);
    #1;
    e = exp_q.pop_front();
    if (if1.rdata1 !== e) begin
      $display("FAIL combo_gpr got=%h exp=%h", if1.rdata1, e);
      n_err++;
    end
    n_cmp++;
    e = exp_q.pop_front();
    if (if1.hi_rdata !== e) begin
      $display("FAIL combo_hi got=%h exp=%h", if1.hi_rdata, e);
      n_err++;
    end
    n_cmp++;
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      if (ph == 0) begin
        drive(1, 1, 32'h77, 32'h88, 1, 5'd31, 32'h99);
        #2 rst = 1'b1;
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
      #1;
      obs = '{if0.rdata1, if0.hi_rdata, if0.lo_rdata, if1.rdata1};
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin
          $display("FAIL combo_rst p%0d[%0d] got=%h exp=%h", ph, k, obs[k], e);
          n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e;
    logic [31:0] obs [4];
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1, 1, 32'hAAAA0000 + i, 32'hBBBB0000 + i,
            1, 5'(i), 32'h01010101 * i);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    raddr(5'd17, 5'd31);
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'hAAAA001F);
    #1;
    e = exp_q.pop_front();
    if (if1.rdata1 !== e) begin
      $display("FAIL prefill_gpr got=%h exp=%h", if1.rdata1, e);
      n_err++;
    end
    n_cmp++;
    e = exp_q.pop_front();
    if (if1.hi_rdata !== e) begin
      $display("FAIL prefill_hi got=%h exp=%h", if1.hi_rdata, e);
      n_err++;
    end
    n_cmp++;
    @(negedge clk);
    drive(1, 1, 32'hC0, 32'hC1, 1, 5'd3, 32'hCAFEF00D);
    raddr(5'd3, 5'd3);
    #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
    #1;
    obs = '{if0.rdata1, if0.hi_rdata, if0.lo_rdata, if1.rdata2};
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      if (obs[k] !== e) begin
        $display("FAIL async_rst[%0d] got=%h exp=%h", k, obs[k], e);
        n_err++;
      end
      n_cmp++;
    end
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
      end
      for (int i = 1; i < 32; i++) begin
        raddr(5'(i), 5'(32 - i));
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        if (if0.rdata1 !== e) begin
          $display("FAIL rst_sweep p%0d r%0d got=%h exp=%h", ph, i, if0.rdata1, e);
          n_err++;
        end
        n_cmp++;
        e = exp_q.pop_front();
        if (if1.rdata2 !== e) begin
          $display("FAIL rst_sweep2 p%0d r%0d got=%h exp=%h", ph, i, if1.rdata2, e);
          n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] m [32];
    logic [31:0] mh, ml, e;
    logic [31:0] obs [8];
    logic [31:0] hd, ld, wd;
    logic        hwe, lwe, we;
    logic [4:0]  wa, a1, a2;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mh = 32'h0;
    ml = 32'h0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      hwe = 1'($urandom_range(0, 1));
      lwe = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 7));
      a1  = 5'($urandom_range(0, 7));
      a2  = (c % 3 == 0) ? wa : 5'($urandom_range(0, 7));
      hd  = hwe ? $urandom : 32'hx;
      ld  = lwe ? $urandom : 32'hx;
      wd  = we ? $urandom : 32'hx;
      drive(hwe, lwe, hd, ld, we, wa, wd);
      raddr(a1, a2);
      exp_q.push_back(a1 == 0 ? 32'h0 :
        (we && wa == a1) ? wd : m[a1]);
      exp_q.push_back(a2 == 0 ? 32'h0 :
        (we && wa == a2) ? wd : m[a2]);
      exp_q.push_back(hwe ? hd : mh);
      exp_q.push_back(lwe ? ld : ml);
      exp_q.push_back(a1 == 0 ? 32'h0 : m[a1]);
      exp_q.push_back(a2 == 0 ? 32'h0 : m[a2]);
      exp_q.push_back(mh);
      exp_q.push_back(ml);
      #1;
      obs = '{if0.rdata1, if0.rdata2, if0.hi_rdata, if0.lo_rdata,
              if1.rdata1, if1.rdata2, if1.hi_rdata, if1.lo_rdata};
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin
          $display("FAIL b2b c%0d[%0d] got=%h exp=%h", c, k, obs[k], e);
          n_err++;
        end
        n_cmp++;
      end
      if (we && wa != 0) m[wa] = wd;
      if (hwe) mh = hd;
      if (lwe) ml = ld;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_gpr();
    test_bypass();
    test_zero();
    test_hilo();
    test_combo_reset();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_rf_hilo.md
Name: wb_rf_hilo

Overview:
- Consumer end of the WB-to-register-file bus in the 5-stage MIPS pipeline.
- Holds the 32x32 general register file and the HI/LO pair.
- Commits writes carried on wb_to_rf_bus at the clock edge, and serves the ID stage two GPR read ports plus HI/LO read ports.
- Optional same-cycle write-through bypass removes the WB->ID hazard window.

Parameters:
- BYPASS, 1: 1 = a read of a register being written this cycle returns the incoming write data; 0 = returns the stored value.
- RF_WD, 104: width of wb_to_rf_bus; equals `WB_TO_RF_WD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wb_to_rf_bus  input  104  packed fields: {hi_we[103], lo_we[102], hi_wdata[101:70], lo_wdata[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- raddr1  input  5  GPR read port 1 address.
- raddr2  input  5  GPR read port 2 address.
- rdata1  output  32  GPR read port 1 data.
- rdata2  output  32  GPR read port 2 data.
- hi_rdata  output  32  current HI value.
- lo_rdata  output  32  current LO value.

Behaviour:
- Reset:
  - On rst high, all 31 GPRs, HI and LO clear to 0 immediately, without waiting for clk.
  - While rst is high, writes are ignored and all read outputs read 0.
  - Deassertion needs no clk edge to take effect.
- GPR write: at posedge clk, if rf_we=1 and rf_waddr!=0, regs[rf_waddr] <= rf_wdata. rf_waddr=0 writes are dropped.
- $0: always reads 0, on both ports, under every condition (bypass included).
- GPR read: combinational, zero-cycle latency from raddrN to rdataN.
- GPR bypass (BYPASS=1): if rf_we=1, rf_waddr!=0 and raddrN==rf_waddr, rdataN = rf_wdata in the same cycle. Both ports may bypass at once.
- BYPASS=0: reads return the stored value; the new value is visible the cycle after the edge.
- HI/LO write: at posedge clk, hi_we=1 loads hi_wdata and lo_we=1 loads lo_wdata. The two enables are independent; both set (mult/div) loads both in the same cycle.
- HI/LO read: hi_rdata / lo_rdata are the stored values. With BYPASS=1, hi_rdata = hi_wdata while hi_we=1 (same for LO).
- The bus is all-zero on WB bubbles (stall/reset of WB); this decodes as no write and must be harmless.
- No stall input: WB already zeroes the bus when stalled, so every cycle's bus content is committed.
- GPR and HI/LO writes in the same cycle are independent and both commit.
- Reset asserted mid-write: reset wins; the register reads 0 afterwards.
- Bus bits are used as-is; X on an enable with the enable low must not corrupt state.

Decomposition:
- Shared package: add field-offset macros to lib/defines.vh:
  - `WB_RF_HI_WE 103, `WB_RF_LO_WE 102
  - `WB_RF_HI 101:70, `WB_RF_LO 69:38
  - `WB_RF_WE 37, `WB_RF_WADDR 36:32, `WB_RF_WDATA 31:0
  - reuse `WB_TO_RF_WD.
- One sub-module, hilo_reg: HI/LO storage with independent enables and the optional bypass.
- The GPR array and its two read muxes stay in the top.

Test Plan:
- Async reset: pulse rst mid-cycle with no clk edge -> rdata1/2, hi_rdata and lo_rdata read 0 immediately, for raddr 1..31.
- GPR write/readback: rf_we=1, waddr=5, wdata=32'hDEADBEEF, then raddr1=5 next cycle -> rdata1=32'hDEADBEEF. With raddr2=6 -> rdata2=0.
- Bypass: BYPASS=1, same cycle rf_we=1, waddr=9, wdata=32'h12345678, raddr1=raddr2=9 -> both read 32'h12345678 before the edge. Repeated with BYPASS=0 -> old value 0 before the edge, new value after it.
- $0 protection: rf_we=1, waddr=0, wdata=32'hFFFFFFFF, raddr1=0 -> rdata1=0 in the same cycle and every following cycle.
- HI/LO independence:
  - cycle A: hi_we=1, lo_we=1, hi=32'h1, lo=32'h2 -> HI=1, LO=2.
  - cycle B: lo_we=1 only, lo=32'h3 -> HI=1, LO=3.
  - cycle C: all-zero bus -> HI=1, LO=3 unchanged.
- Simultaneous GPR and HI write plus reset mid-operation: rf_we=1 waddr=31 wdata=32'hA5A5A5A5 with hi_we=1 hi=32'h5A5A5A5A -> both visible next cycle. Then assert rst -> all read 0; deassert -> still 0 until rewritten.
